// File: rtl/paralelo_serial_param.sv
// -----------------------------------------------------------------------------
// paralelo_serial_param
//
// Parallel-to-serial converter for the serial PHY path. One bit leaves on
// every rising edge of clk_32f. Words are WIDTH bits wide and are sent MSB
// first (LSB_FIRST=0) or LSB first (LSB_FIRST=1). After reset, SYNC_WORDS
// COMMA words are sent as a preamble before any data is accepted. Whenever
// no data word is pending at a word boundary, a full COMMA word is sent.
//
// Ports:
//   clk_32f    in   serial bit clock, all state changes on its rising edge
//   reset_L    in   asynchronous active-low reset
//   data_in    in   parallel word from the upstream stage (WIDTH bits)
//   valid_in   in   data_in is valid
//   ready_out  out  one-word holding buffer can accept a word
//   data_out   out  registered serial bit stream
//   word_start out  data_out carries the first bit of a word
//   is_data    out  word on data_out came from data_in, not COMMA
//   sync_done  out  comma preamble complete
//   state_dbg  out  current FSM state (0 = SYNC, 1 = RUN)
//
// Handshake: a word is transferred into the holding buffer on a rising edge
// where valid_in && ready_out. ready_out is decoded from registers only, so
// it never depends on valid_in in the same cycle. The source must keep
// data_in and valid_in stable until the transfer edge.
// -----------------------------------------------------------------------------
module paralelo_serial_param #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = WIDTH'(8'hBC),
  parameter int               SYNC_WORDS = 4,
  parameter bit               LSB_FIRST  = 1'b0
) (
  input  logic             clk_32f,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             data_out,
  output logic             word_start,
  output logic             is_data,
  output logic             sync_done,
  output logic             state_dbg
);

  localparam int CNT_W  = $clog2(WIDTH);
  // Keep the sync counter at least one bit wide even with no preamble.
  localparam int SW_MAX = (SYNC_WORDS > 0) ? SYNC_WORDS : 1;
  localparam int SC_W   = $clog2(SW_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [SC_W-1:0]  SYNC_LAST = SC_W'(SW_MAX - 1);
  localparam bit               NO_SYNC   = (SYNC_WORDS == 0);

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // FSM registers
  state_t            state_q, state_d;
  logic [SC_W-1:0]   sync_cnt_q, sync_cnt_d;
  logic              sync_done_q, sync_done_d;

  // Datapath registers
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  cur_q, cur_d;
  logic [WIDTH-1:0]  hold_q, hold_d;
  logic              hold_valid_q, hold_valid_d;
  logic              data_out_q, data_out_d;
  logic              word_start_q, word_start_d;
  logic              is_data_q, is_data_d;

  // Decoded controls
  logic              wrap;
  logic              boundary;
  logic              load_hold;
  logic              take;
  logic [WIDTH-1:0]  next_word;
  logic              first_bit;
  logic [CNT_W-1:0]  bit_idx;

  assign wrap     = (cnt_q == CNT_LAST);
  assign boundary = (cnt_q == '0);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= ST_SYNC;
      sync_cnt_q  <= '0;
      sync_done_q <= NO_SYNC;
    end else begin
      state_q     <= state_d;
      sync_cnt_q  <= sync_cnt_d;
      sync_done_q <= sync_done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    sync_cnt_d  = sync_cnt_q;
    sync_done_d = sync_done_q;
    case (state_q)
      ST_SYNC: begin
        if (NO_SYNC) begin
          // No preamble: leave SYNC on the first edge. The word loaded on
          // that edge is still COMMA, since nothing can be held yet.
          state_d     = ST_RUN;
          sync_done_d = 1'b1;
        end else if (wrap) begin
          sync_cnt_d = sync_cnt_q + 1'b1;
          // Last comma bit of the last preamble word goes out on this edge.
          if (sync_cnt_q == SYNC_LAST) begin
            state_d     = ST_RUN;
            sync_done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        sync_done_d = 1'b1;
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // The load looks at hold_valid before the edge, so a word transferred on
    // a boundary edge waits for the next boundary.
    load_hold = boundary && (state_q == ST_RUN) && hold_valid_q;
    next_word = load_hold ? hold_q : COMMA;
    first_bit = LSB_FIRST ? next_word[0] : next_word[WIDTH-1];
    // reset_L gates ready so it reads 0 while reset is held, even when the
    // preamble is disabled and sync_done resets to 1.
    ready_out = sync_done_q && !hold_valid_q && reset_L;
    take      = valid_in && ready_out;
  end

  assign sync_done = sync_done_q;
  assign state_dbg = state_q;

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d        = wrap ? '0 : cnt_q + 1'b1;
    bit_idx      = LSB_FIRST ? cnt_q : (CNT_LAST - cnt_q);
    cur_d        = cur_q;
    data_out_d   = cur_q[bit_idx];
    word_start_d = 1'b0;
    is_data_d    = is_data_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;

    if (boundary) begin
      cur_d        = next_word;
      data_out_d   = first_bit;
      word_start_d = 1'b1;
      is_data_d    = load_hold;
    end

    // take and load_hold are exclusive: take needs an empty buffer,
    // load_hold needs a full one.
    if (load_hold) begin
      hold_valid_d = 1'b0;
    end
    if (take) begin
      hold_d       = data_in;
      hold_valid_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      cnt_q        <= '0;
      cur_q        <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      data_out_q   <= 1'b0;
      word_start_q <= 1'b0;
      is_data_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      cur_q        <= cur_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      data_out_q   <= data_out_d;
      word_start_q <= word_start_d;
      is_data_q    <= is_data_d;
    end
  end

  assign data_out   = data_out_q;
  assign word_start = word_start_q;
  assign is_data    = is_data_q;

endmodule
